// File: rtl/alu_mult_sequencer.sv
// Shift-and-add MULTU sequencer that borrows the shared ALU for 32 cycles per product.
// Optional macro MULT_ZERO_SKIP_EN: a zero operand skips RUN and goes straight to DONE.
module alu_mult_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] mcand_in,
  input  logic [WIDTH-1:0] mplier_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  input  logic [2:0]       dp_ctl,
  input  logic [WIDTH-1:0] dp_dataA,
  input  logic [WIDTH-1:0] dp_dataB,
  output logic [2:0]       alu_ctl,
  output logic [WIDTH-1:0] alu_dataA,
  output logic [WIDTH-1:0] alu_dataB,
  input  logic [WIDTH-1:0] alu_dataOut
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;
  localparam logic [2:0] ALU_ADD = 3'b010;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             zero_op;

  // The ALU has no carry output, so the add carry is rebuilt from the operand and sum MSBs.
  always_comb begin
    sum   = alu_dataOut;
    carry = (hi_q[WIDTH-1] & mcand_q[WIDTH-1]) |
            ((hi_q[WIDTH-1] | mcand_q[WIDTH-1]) & ~sum[WIDTH-1]);
  end

`ifdef MULT_ZERO_SKIP_EN
  assign zero_op = (mcand_in == '0) || (mplier_in == '0);
`else
  assign zero_op = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    mcand_d = mcand_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d = mcand_in;
          count_d = '0;
          hi_d    = '0;
          if (zero_op) begin
            lo_d    = '0;
            state_d = S_DONE;
          end else begin
            lo_d    = mplier_in;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (lo_q[0]) begin
          {hi_d, lo_d} = {carry, sum, lo_q[WIDTH-1:1]};
        end else begin
          {hi_d, lo_d} = {1'b0, hi_q, lo_q[WIDTH-1:1]};
        end
        count_d = count_q + CNT_W'(1);
        if (count_q == CNT_W'(WIDTH-1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      mcand_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mcand_q <= mcand_d;
      count_q <= count_d;
    end
  end

  // The sequencer owns the ALU only while iterating; otherwise the datapath passes straight through.
  always_comb begin
    alu_ctl   = dp_ctl;
    alu_dataA = dp_dataA;
    alu_dataB = dp_dataB;
    if (state_q == S_RUN) begin
      alu_ctl   = ALU_ADD;
      alu_dataA = hi_q;
      alu_dataB = mcand_q;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
